// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: LATENCY-deep pipelined EX-stage integer ALU feeding the CDB.
// Define ALU_PIPE_FLUSH_EN to let flush_i kill every in-flight instruction.
module alu_pipe_unit #(
    parameter int LATENCY         = 1,
    parameter int TAG_W           = 6,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int ALU_OP_WIDTH    = 4,
    parameter int SRC_A_SEL_WIDTH = 2,
    parameter int SRC_B_SEL_WIDTH = 2,
    localparam int CNT_W          = $clog2(LATENCY + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       issue_i,
    output logic                       ready_o,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic [DATA_W-1:0]          imm_i,
    input  logic [DATA_W-1:0]          src1_i,
    input  logic [DATA_W-1:0]          src2_i,
    input  logic [ALU_OP_WIDTH-1:0]    alu_op_i,
    input  logic [SRC_A_SEL_WIDTH-1:0] src_a_select_i,
    input  logic [SRC_B_SEL_WIDTH-1:0] src_b_select_i,
    input  logic                       if_write_rrf_i,
    input  logic [TAG_W-1:0]           rrf_tag_i,
    input  logic [TAG_W-1:0]           rob_tag_i,
    input  logic                       wb_grant_i,
    input  logic                       flush_i,
    output logic [DATA_W-1:0]          result_o,
    output logic [TAG_W-1:0]           rrf_tag_o,
    output logic [TAG_W-1:0]           rob_tag_o,
    output logic                       rob_we_o,
    output logic                       rrf_we_o,
    output logic [CNT_W-1:0]           inflight_o
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_PASB = ALU_OP_WIDTH'(10);

    localparam logic [SRC_A_SEL_WIDTH-1:0] SRCA_RS1 = SRC_A_SEL_WIDTH'(0);
    localparam logic [SRC_A_SEL_WIDTH-1:0] SRCA_PC  = SRC_A_SEL_WIDTH'(1);

    localparam logic [SRC_B_SEL_WIDTH-1:0] SRCB_RS2 = SRC_B_SEL_WIDTH'(0);
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRCB_IMM = SRC_B_SEL_WIDTH'(1);
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRCB_4   = SRC_B_SEL_WIDTH'(2);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  rrf_tag;
        logic [TAG_W-1:0]  rob_tag;
        logic              wr_rrf;
    } stage_t;

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [SH_W-1:0]     sh;
    logic [DATA_W-1:0]   alu_res;
    stage_t              issue_pay;
    logic [LATENCY-1:0]  valid_q, valid_d;
    stage_t [LATENCY-1:0] pay_q, pay_d;
    logic [LATENCY-1:0]  adv;
    logic                kill;

`ifdef ALU_PIPE_FLUSH_EN
    assign kill = flush_i;
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign kill = 1'b0;
`endif

    always_comb begin
        op_a = '0;
        case (src_a_select_i)
            SRCA_RS1: op_a = src1_i;
            SRCA_PC:  op_a = DATA_W'(pc_i);
            default:  op_a = '0;
        endcase
    end

    always_comb begin
        op_b = '0;
        case (src_b_select_i)
            SRCB_RS2: op_b = src2_i;
            SRCB_IMM: op_b = imm_i;
            SRCB_4:   op_b = DATA_W'(4);
            default:  op_b = '0;
        endcase
    end

    assign sh = op_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << sh;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, op_a < op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> sh;
            OP_SRA:  alu_res = DATA_W'($signed(op_a) >>> sh);
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_PASB: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    assign issue_pay = '{result:  alu_res,
                         rrf_tag: rrf_tag_i,
                         rob_tag: rob_tag_i,
                         wr_rrf:  if_write_rrf_i};

    // A stage may move when a grant frees the tail or any later stage is a bubble.
    always_comb begin : adv_calc
        logic full;
        adv = '0;
        full = 1'b1;
        for (int k = 0; k < LATENCY; k++) begin
            full = 1'b1;
            for (int j = k; j < LATENCY; j++) begin
                full = full & valid_q[j];
            end
            adv[k] = wb_grant_i | ~full;
        end
    end

    assign ready_o = adv[0];

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (adv[0]) begin
            valid_d[0] = issue_i;
            if (issue_i) begin
                pay_d[0] = issue_pay;
            end
        end
        for (int k = 1; k < LATENCY; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                pay_d[k]   = pay_q[k-1];
            end
        end
        if (kill) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    always_comb begin
        inflight_o = '0;
        for (int k = 0; k < LATENCY; k++) begin
            inflight_o = inflight_o + CNT_W'(valid_q[k]);
        end
    end

    assign result_o  = pay_q[LATENCY-1].result;
    assign rrf_tag_o = pay_q[LATENCY-1].rrf_tag;
    assign rob_tag_o = pay_q[LATENCY-1].rob_tag;
    assign rob_we_o  = valid_q[LATENCY-1];
    assign rrf_we_o  = valid_q[LATENCY-1] & wb_grant_i
                     & pay_q[LATENCY-1].wr_rrf & ~kill;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Bench for alu_pipe_unit: LATENCY=3 and LATENCY=1 instances on shared inputs,
// checked against a queue/position model of the pipeline.
module tb_alu_pipe_unit;

`ifdef ALU_PIPE_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, issue, grant, flush, wr;
    logic [31:0] pc, imm, s1, s2;
    logic [3:0]  op;
    logic [1:0]  sa, sb;
    logic [5:0]  rrf_t, rob_t;

    logic        r3_ready, r3_rob_we, r3_rrf_we;
    logic [31:0] r3_res;
    logic [5:0]  r3_rrf, r3_rob;
    logic [1:0]  r3_inf;

    logic        r1_ready, r1_rob_we, r1_rrf_we;
    logic [31:0] r1_res;
    logic [5:0]  r1_rrf, r1_rob;
    logic [0:0]  r1_inf;

    int n_cmp = 0;
    int n_bad = 0;

    alu_pipe_unit #(.LATENCY(3)) u3 (
        .clk_i(clk), .reset_i(reset), .issue_i(issue), .ready_o(r3_ready),
        .pc_i(pc), .imm_i(imm), .src1_i(s1), .src2_i(s2),
        .alu_op_i(op), .src_a_select_i(sa), .src_b_select_i(sb),
        .if_write_rrf_i(wr), .rrf_tag_i(rrf_t), .rob_tag_i(rob_t),
        .wb_grant_i(grant), .flush_i(flush),
        .result_o(r3_res), .rrf_tag_o(r3_rrf), .rob_tag_o(r3_rob),
        .rob_we_o(r3_rob_we), .rrf_we_o(r3_rrf_we), .inflight_o(r3_inf)
    );

    alu_pipe_unit #(.LATENCY(1)) u1 (
        .clk_i(clk), .reset_i(reset), .issue_i(issue), .ready_o(r1_ready),
        .pc_i(pc), .imm_i(imm), .src1_i(s1), .src2_i(s2),
        .alu_op_i(op), .src_a_select_i(sa), .src_b_select_i(sb),
        .if_write_rrf_i(wr), .rrf_tag_i(rrf_t), .rob_tag_i(rob_t),
        .wb_grant_i(grant), .flush_i(flush),
        .result_o(r1_res), .rrf_tag_o(r1_rrf), .rob_tag_o(r1_rob),
        .rob_we_o(r1_rob_we), .rrf_we_o(r1_rrf_we), .inflight_o(r1_inf)
    );

    // Reference ALU: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 B.
    function automatic logic [31:0] ref_alu(input logic [3:0] o,
                                            input logic [1:0] a_s, b_s,
                                            input logic [31:0] p, i, x, y);
        logic [31:0] a, b;
        a = (a_s == 2'd0) ? x : (a_s == 2'd1) ? p : 32'd0;
        b = (b_s == 2'd0) ? y : (b_s == 2'd1) ? i : (b_s == 2'd2) ? 32'd4 : 32'd0;
        case (o)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return {31'd0, $signed(a) < $signed(b)};
            4'd4:    return {31'd0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    // Model of the LATENCY=3 unit: ordered entries, each at a stage position 0..2.
    typedef struct {
        logic [31:0] res;
        logic [5:0]  rrf;
        logic [5:0]  rob;
        logic        wr;
        int          pos;
    } ent_t;

    ent_t mq[$];
    ent_t nq[$];

    // Builds nq = state after the coming edge (before any capture); returns ready.
    function automatic bit plan(input bit g);
        nq = mq;
        if (nq.size() > 0 && nq[0].pos == 2 && g) void'(nq.pop_front());
        for (int i = 0; i < nq.size(); i++) begin
            ent_t e;
            int lim;
            e = nq[i];
            lim = (i == 0) ? 2 : nq[i-1].pos - 1;
            if (e.pos < lim) e.pos = e.pos + 1;
            nq[i] = e;
        end
        return nq.size() == 0 || nq[nq.size()-1].pos > 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_add(input logic [31:0] x, input logic [31:0] y,
                           input logic [5:0] tag);
        op = 4'd0; sa = 2'd0; sb = 2'd0;
        s1 = x; s2 = y; rob_t = tag; rrf_t = tag + 6'd1; wr = 1'b1;
    endtask

    task automatic drive_rand();
        op    = 4'($urandom_range(0, 11));
        sa    = 2'($urandom_range(0, 3));
        sb    = 2'($urandom_range(0, 3));
        pc    = $urandom;
        imm   = $urandom;
        s1    = $urandom;
        s2    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        rrf_t = 6'($urandom);
        rob_t = 6'($urandom);
        wr    = 1'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; issue = 1'b0; grant = 1'b0; flush = 1'b0;
        tick();
        reset = 1'b0;
        mq.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; issue = 1'b0; grant = 1'b0; flush = 1'b0;
        set_add(32'd0, 32'd0, 6'd0); pc = 32'd0; imm = 32'd0;
        tick();
        tick();
        n_cmp++; if (r3_rob_we !== 1'b0) begin n_bad++; $display("FAIL rst_rob_we: got %b want 0", r3_rob_we); end
        n_cmp++; if (r3_rrf_we !== 1'b0) begin n_bad++; $display("FAIL rst_rrf_we: got %b want 0", r3_rrf_we); end
        n_cmp++; if (r3_inf !== 2'd0) begin n_bad++; $display("FAIL rst_inflight: got %0d want 0", r3_inf); end
        n_cmp++; if (r3_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", r3_ready); end
        n_cmp++; if ({r3_res, r3_rob, r3_rrf} !== 44'd0) begin n_bad++; $display("FAIL rst_payload: got %h want 0", {r3_res, r3_rob, r3_rrf}); end
        n_cmp++; if ({r1_rob_we, r1_inf, r1_ready} !== 3'b001) begin n_bad++; $display("FAIL rst_l1: got %b want 001", {r1_rob_we, r1_inf, r1_ready}); end
        reset = 1'b0;
    endtask

    task automatic test_latency1();
        do_reset();
        grant = 1'b1; issue = 1'b1;
        set_add(32'd5, 32'd7, 6'd3);
        tick();
        issue = 1'b0;
        #1;
        n_cmp++; if (r1_rob_we !== 1'b1) begin n_bad++; $display("FAIL l1_rob_we: got %b want 1", r1_rob_we); end
        n_cmp++; if (r1_res !== 32'd12) begin n_bad++; $display("FAIL l1_result: got %0d want 12", r1_res); end
        n_cmp++; if (r1_rob !== 6'd3) begin n_bad++; $display("FAIL l1_rob_tag: got %0d want 3", r1_rob); end
        n_cmp++; if (r1_rrf_we !== 1'b1) begin n_bad++; $display("FAIL l1_rrf_we: got %b want 1", r1_rrf_we); end
        tick();
    endtask

    task automatic test_lat1_stream();
        bit          exp_we;
        logic [31:0] exp_res;
        logic [5:0]  exp_rob;
        do_reset();
        grant = 1'b1; exp_we = 1'b0; exp_res = '0; exp_rob = '0;
        for (int c = 0; c < 24; c++) begin
            drive_rand();
            issue = 1'($urandom);
            #1;
            n_cmp++; if (r1_ready !== 1'b1) begin n_bad++; $display("FAIL l1s_ready c%0d: got %b want 1", c, r1_ready); end
            n_cmp++; if (r1_rob_we !== exp_we) begin n_bad++; $display("FAIL l1s_rob_we c%0d: got %b want %b", c, r1_rob_we, exp_we); end
            if (exp_we) begin
                n_cmp++; if (r1_res !== exp_res) begin n_bad++; $display("FAIL l1s_result c%0d: got %h want %h", c, r1_res, exp_res); end
                n_cmp++; if (r1_rob !== exp_rob) begin n_bad++; $display("FAIL l1s_rob_tag c%0d: got %0d want %0d", c, r1_rob, exp_rob); end
            end
            exp_we  = issue;
            exp_res = ref_alu(op, sa, sb, pc, imm, s1, s2);
            exp_rob = rob_t;
            tick();
        end
        issue = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          peak, cap, ret;
        bit          exp_we;
        logic [31:0] exp_res;
        do_reset();
        grant = 1'b1; peak = 0;
        for (int c = 0; c < 8; c++) begin
            issue = (c < 4);
            set_add(32'(c * 1000 + 17), 32'(c), 6'(c + 10));
            tick();
            cap = (c + 1 < 4) ? c + 1 : 4;
            ret = (c >= 3) ? ((c - 2 < 4) ? c - 2 : 4) : 0;
            exp_we  = (c >= 2 && c <= 5);
            exp_res = 32'((c - 2) * 1000 + 17 + (c - 2));
            if (int'(r3_inf) > peak) peak = int'(r3_inf);
            n_cmp++; if (r3_inf !== 2'(cap - ret)) begin n_bad++; $display("FAIL b2b_inflight c%0d: got %0d want %0d", c, r3_inf, cap - ret); end
            n_cmp++; if (r3_rob_we !== exp_we) begin n_bad++; $display("FAIL b2b_rob_we c%0d: got %b want %b", c, r3_rob_we, exp_we); end
            if (exp_we) begin
                n_cmp++; if (r3_res !== exp_res) begin n_bad++; $display("FAIL b2b_result c%0d: got %0d want %0d", c, r3_res, exp_res); end
            end
        end
        n_cmp++; if (peak != 3) begin n_bad++; $display("FAIL b2b_peak: got %0d want 3", peak); end
        issue = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        grant = 1'b0;
        for (int c = 0; c < 6; c++) begin
            issue = 1'b1;
            set_add((c < 3) ? 32'(100 + c) : 32'hDEAD, 32'd0, 6'(20 + c));
            #1;
            n_cmp++; if (r3_ready !== (c < 3)) begin n_bad++; $display("FAIL stall_ready c%0d: got %b want %b", c, r3_ready, c < 3); end
            tick();
            n_cmp++; if (r3_inf !== 2'((c < 2) ? c + 1 : 3)) begin n_bad++; $display("FAIL stall_inflight c%0d: got %0d", c, r3_inf); end
            if (c >= 2) begin
                n_cmp++; if (r3_rob_we !== 1'b1 || r3_res !== 32'd100) begin n_bad++; $display("FAIL stall_hold c%0d: got we=%b res=%h want we=1 res=64", c, r3_rob_we, r3_res); end
            end
        end
        issue = 1'b0; grant = 1'b1;
        for (int d = 0; d < 6; d++) begin
            #1;
            n_cmp++; if (r3_rob_we !== (d < 3)) begin n_bad++; $display("FAIL drain_rob_we d%0d: got %b want %b", d, r3_rob_we, d < 3); end
            if (d < 3) begin
                n_cmp++; if (r3_res !== 32'(100 + d)) begin n_bad++; $display("FAIL drain_result d%0d: got %h want %h", d, r3_res, 100 + d); end
                n_cmp++; if (r3_rrf_we !== 1'b1) begin n_bad++; $display("FAIL drain_rrf_we d%0d: got %b want 1", d, r3_rrf_we); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [31:0] got[$];
        logic [31:0] want[$];
        do_reset();
        grant = 1'b0;
        issue = 1'b1; set_add(32'd300, 32'd0, 6'd1); tick();
        issue = 1'b1; set_add(32'd301, 32'd0, 6'd2); tick();
        issue = 1'b0; tick();
        flush = 1'b1; grant = 1'b1; issue = 1'b1;
        set_add(32'd302, 32'd0, 6'd3);
        #1;
        n_cmp++; if (r3_rrf_we !== !FLUSH_ON) begin n_bad++; $display("FAIL flush_rrf_we: got %b want %b", r3_rrf_we, !FLUSH_ON); end
        tick();
        flush = 1'b0; issue = 1'b0;
        n_cmp++; if (r3_inf !== (FLUSH_ON ? 2'd0 : 2'd2)) begin n_bad++; $display("FAIL flush_inflight: got %0d want %0d", r3_inf, FLUSH_ON ? 0 : 2); end
        for (int c = 0; c < 5; c++) begin
            if (r3_rob_we) got.push_back(r3_res);
            tick();
        end
        if (!FLUSH_ON) begin
            want.push_back(32'd301);
            want.push_back(32'd302);
        end
        n_cmp++; if (got.size() != want.size()) begin n_bad++; $display("FAIL flush_count: got %0d want %0d", got.size(), want.size()); end
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL flush_order %0d: got %0d want %0d", i, got[i], want[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        grant = 1'b0;
        issue = 1'b1; set_add(32'd400, 32'd0, 6'd5); tick();
        issue = 1'b1; set_add(32'd401, 32'd0, 6'd6); tick();
        issue = 1'b0; reset = 1'b1;
        tick();
        n_cmp++; if ({r3_rob_we, r3_rrf_we, r3_inf, r3_ready} !== 5'b00001) begin n_bad++; $display("FAIL rmid_ctl: got %b want 00001", {r3_rob_we, r3_rrf_we, r3_inf, r3_ready}); end
        n_cmp++; if ({r3_res, r3_rob, r3_rrf} !== 44'd0) begin n_bad++; $display("FAIL rmid_payload: got %h want 0", {r3_res, r3_rob, r3_rrf}); end
        reset = 1'b0; grant = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (r3_rob_we !== 1'b0) begin n_bad++; $display("FAIL rmid_ghost c%0d: got %b want 0", c, r3_rob_we); end
        end
    endtask

    task automatic test_random();
        bit rdy, exp_we, exp_rrf;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive_rand();
            issue = ($urandom_range(0, 3) != 0);
            grant = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            #1;
            rdy     = plan(grant);
            exp_we  = mq.size() > 0 && mq[0].pos == 2;
            exp_rrf = exp_we && grant && mq[0].wr && !(FLUSH_ON && flush);
            n_cmp++; if (r3_ready !== rdy) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, r3_ready, rdy); end
            n_cmp++; if (r3_rob_we !== exp_we) begin n_bad++; $display("FAIL rnd_rob_we c%0d: got %b want %b", c, r3_rob_we, exp_we); end
            n_cmp++; if (r3_rrf_we !== exp_rrf) begin n_bad++; $display("FAIL rnd_rrf_we c%0d: got %b want %b", c, r3_rrf_we, exp_rrf); end
            n_cmp++; if (r3_inf !== 2'(mq.size())) begin n_bad++; $display("FAIL rnd_inflight c%0d: got %0d want %0d", c, r3_inf, mq.size()); end
            if (exp_we) begin
                n_cmp++; if (r3_res !== mq[0].res) begin n_bad++; $display("FAIL rnd_result c%0d: got %h want %h", c, r3_res, mq[0].res); end
                n_cmp++; if (r3_rob !== mq[0].rob || r3_rrf !== mq[0].rrf) begin n_bad++; $display("FAIL rnd_tags c%0d: got %0d/%0d want %0d/%0d", c, r3_rob, r3_rrf, mq[0].rob, mq[0].rrf); end
            end
            if (FLUSH_ON && flush) begin
                mq.delete();
            end else begin
                mq = nq;
                if (issue && rdy)
                    mq.push_back('{ref_alu(op, sa, sb, pc, imm, s1, s2), rrf_t, rob_t, wr, 0});
            end
            tick();
        end
        issue = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency1();
        test_lat1_stream();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
